// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the 16-bit ALU datapath.
// Holds up to two results, with their {Z,N,V} flags, in a small FIFO behind
// a valid/ready handshake. Also keeps a sticky overflow flag and a saturating
// overflow event counter for the control FSM.
// Optional feature: define ALU_SAT_EN to replace an overflowing result with
// the saturated value chosen by the sign of operand A.
module alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_ovf,
   input  logic             in_a_msb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_flags,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             clr_sticky
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t state;
   occ_t state_nx;

   logic [WIDTH-1:0] data_mem [2];
   logic [2:0]       flag_mem [2];
   logic             rd_ptr;
   logic             wr_ptr;

   logic             accept;
   logic             pop;
   logic [WIDTH-1:0] store_result;
   logic [2:0]       store_flags;

   assign accept     = in_valid & in_ready;
   assign out_valid  = (state != EMPTY);
   assign pop        = out_valid & out_ready;
   assign out_result = data_mem[rd_ptr];
   assign out_flags  = flag_mem[rd_ptr];

`ifdef ALU_SAT_EN
   // Overflowing results are clamped toward the sign of operand A before storage
   always_comb begin
      store_result = in_result;
      if (in_ovf) begin
         if (in_a_msb) begin
            store_result = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            store_result = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end
   end
`else
   logic unused_a_msb;
   assign unused_a_msb = in_a_msb;

   // Results are stored exactly as produced (wrapped on overflow)
   always_comb begin
      store_result = in_result;
   end
`endif

   // Flags always describe the word that is actually stored
   always_comb begin
      store_flags = {(store_result == '0), store_result[WIDTH-1], in_ovf};
   end

   // Occupancy next-state; FULL never sees an accept because in_ready is low there
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nx = ONE;
            end
         end
         ONE: begin
            if (accept && !pop) begin
               state_nx = FULL;
            end else if (pop && !accept) begin
               state_nx = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_nx = ONE;
            end
         end
         default: begin
            state_nx = EMPTY;
         end
      endcase
   end

   // Occupancy register and registered in_ready, held low while reset is asserted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nx;
         in_ready <= (state_nx != FULL);
      end
   end

   // FIFO storage and pointers; reset clears entries so the head reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            data_mem[i] <= '0;
            flag_mem[i] <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (accept) begin
            data_mem[wr_ptr] <= store_result;
            flag_mem[wr_ptr] <= store_flags;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // Sticky overflow and saturating event counter; a clear beats a same-cycle event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
         ovf_count  <= '0;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
         ovf_count  <= '0;
      end else if (accept && in_ovf) begin
         sticky_ovf <= 1'b1;
         if (ovf_count != '1) begin
            ovf_count <= ovf_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed checks of alu_result_stage (reset, FIFO order,
// simultaneous accept/pop, flags, overflow bookkeeping) followed by a throttled
// stream compared against a queue of accepted words.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_ovf;
   logic        in_a_msb;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [2:0]  out_flags;
   logic        sticky_ovf;
   logic [7:0]  ovf_count;
   logic        clr_sticky;

   int checks = 0;
   int errors = 0;

   logic [15:0] expPos;
   logic [15:0] expNeg;
   logic [2:0]  expNegFlags;

   alu_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_ovf     (in_ovf),
      .in_a_msb   (in_a_msb),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .sticky_ovf (sticky_ovf),
      .ovf_count  (ovf_count),
      .clr_sticky (clr_sticky)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic v, input logic [15:0] r, input logic o,
                                input logic m, input logic ordy, input logic clr);
      in_valid   = v;
      in_result  = r;
      in_ovf     = o;
      in_a_msb   = m;
      out_ready  = ordy;
      clr_sticky = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flagsOf(input logic [15:0] r, input logic v);
      return {(r == 16'h0000), r[15], v};
   endfunction

   initial begin
      logic [15:0] sbq[$];
      logic [15:0] word;
      logic [15:0] prevR;
      logic [2:0]  prevF;
      logic        hold;
      logic        vIn;
      logic        rdy;
      int          sent;
      int          rcvd;

`ifdef ALU_SAT_EN
      expPos      = 16'h7FFF;
      expNeg      = 16'h8000;
      expNegFlags = 3'b011;
`else
      expPos      = 16'h4000;
      expNeg      = 16'h0000;
      expNegFlags = 3'b101;
`endif

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      checkOutput("rst_out_valid", 32'(out_valid), 'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 'h0);
      checkOutput("rst_out_result", 32'(out_result), 'h0);
      checkOutput("rst_out_flags", 32'(out_flags), 'h0);
      checkOutput("rst_sticky", 32'(sticky_ovf), 'h0);
      checkOutput("rst_count", 32'(ovf_count), 'h0);
      #1 rst_n = 1'b1;
      checkOutput("rel_in_ready_low", 32'(in_ready), 'h0);
      step();
      checkOutput("rel_in_ready_high", 32'(in_ready), 'h1);
      $display("[TB] reset checks done");

      // ---------------- fill to FULL, then drain in order ----------------
      applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("fill1_valid", 32'(out_valid), 'h1);
      checkOutput("fill1_result", 32'(out_result), 'h0001);
      checkOutput("fill1_in_ready", 32'(in_ready), 'h1);
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("full_in_ready", 32'(in_ready), 'h0);
      checkOutput("full_head", 32'(out_result), 'h0001);
      applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("full_hold_result", 32'(out_result), 'h0001);
      checkOutput("full_hold_flags", 32'(out_flags), 'h0);
      checkOutput("full_hold_in_ready", 32'(in_ready), 'h0);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("drain1_result", 32'(out_result), 'h0000);
      checkOutput("drain1_flags", 32'(out_flags), 'h4);
      checkOutput("drain1_in_ready", 32'(in_ready), 'h1);
      checkOutput("drain1_valid", 32'(out_valid), 'h1);
      step();
      checkOutput("drain2_valid", 32'(out_valid), 'h0);

      // ---------------- ONE with simultaneous accept and pop ----------------
      applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("swap_valid", 32'(out_valid), 'h1);
      checkOutput("swap_result", 32'(out_result), 'h8000);
      checkOutput("swap_flags", 32'(out_flags), 'h2);
      checkOutput("swap_in_ready", 32'(in_ready), 'h1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("swap_drained", 32'(out_valid), 'h0);

      // ---------------- overflow capture and saturation ----------------
      applyStimulus(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("ovf_pos_result", 32'(out_result), 32'(expPos));
      checkOutput("ovf_pos_flags", 32'(out_flags), 'h1);
      checkOutput("ovf_pos_sticky", 32'(sticky_ovf), 'h1);
      checkOutput("ovf_pos_count", 32'(ovf_count), 'h1);
      applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      checkOutput("ovf_neg_result", 32'(out_result), 32'(expNeg));
      checkOutput("ovf_neg_flags", 32'(out_flags), 32'(expNegFlags));
      checkOutput("ovf_neg_count", 32'(ovf_count), 'h2);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      checkOutput("clr_sticky", 32'(sticky_ovf), 'h0);
      checkOutput("clr_count", 32'(ovf_count), 'h0);
      checkOutput("clr_drained", 32'(out_valid), 'h0);

      // ---------------- counter saturation and clear priority ----------------
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 1'b0);
         step();
      end
      checkOutput("count_255", 32'(ovf_count), 'hFF);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 1'b0);
         step();
      end
      checkOutput("count_sat", 32'(ovf_count), 'hFF);
      checkOutput("count_sticky", 32'(sticky_ovf), 'h1);
      applyStimulus(1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      checkOutput("clrwin_count", 32'(ovf_count), 'h0);
      checkOutput("clrwin_sticky", 32'(sticky_ovf), 'h0);
      checkOutput("clrwin_flags", 32'(out_flags), 'h1);
`ifdef ALU_SAT_EN
      checkOutput("clrwin_result", 32'(out_result), 'h7FFF);
`else
      checkOutput("clrwin_result", 32'(out_result), 'h0002);
`endif
      applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("noovf_count", 32'(ovf_count), 'h0);
      checkOutput("noovf_result", 32'(out_result), 'h0003);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      checkOutput("sat_drained", 32'(out_valid), 'h0);

      // ---------------- reset while FULL ----------------
      applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      checkOutput("prerst_in_ready", 32'(in_ready), 'h0);
      checkOutput("prerst_sticky", 32'(sticky_ovf), 'h1);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 'h0);
      checkOutput("midrst_sticky", 32'(sticky_ovf), 'h0);
      checkOutput("midrst_count", 32'(ovf_count), 'h0);
      checkOutput("midrst_result", 32'(out_result), 'h0);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("postrst_in_ready", 32'(in_ready), 'h1);
      checkOutput("postrst_valid", 32'(out_valid), 'h0);

      // ---------------- throttled stream against a queue ----------------
      sent = 0;
      rcvd = 0;
      hold = 1'b0;
      prevR = '0;
      prevF = '0;
      for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
         if (hold) begin
            checkOutput("rand_stable", {12'h0, out_valid, out_flags, out_result},
                        {12'h0, 1'b1, prevF, prevR});
         end
         vIn  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         rdy  = ($urandom_range(0, 2) != 0);
         word = 16'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            word = 16'h0000;
         end
         if (out_valid && rdy) begin
            if (sbq.size() == 0) begin
               checkOutput("rand_extra", 32'(out_result), 'hDEAD0000);
            end else begin
               checkOutput("rand_data", 32'(out_result), 32'(sbq[0]));
               checkOutput("rand_flags", 32'(out_flags), 32'(flagsOf(sbq[0], 1'b0)));
               void'(sbq.pop_front());
            end
            rcvd++;
         end
         if (vIn && in_ready) begin
            sbq.push_back(word);
            sent++;
         end
         hold  = out_valid && !rdy;
         prevR = out_result;
         prevF = out_flags;
         applyStimulus(vIn, word, 1'b0, 1'b0, rdy, 1'b0);
         step();
      end
      checkOutput("rand_received", 32'(rcvd), 32'd1000);
      checkOutput("rand_leftover", 32'(sbq.size()), 'h0);
      checkOutput("rand_final_valid", 32'(out_valid), 'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
